uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
//   UART transmitter that drains the TX FIFO: pops one word whenever the FIFO is non-empty and idle/finishing.
//   Serialises it as start bit, DBIT data bits LSB first, optional parity, stop bit(s), timed by 16x oversample ticks.
//   Sits directly downstream of the TX fifo (its r_data/empty/rd); s_tick comes from the shared baud generator.
//
// PARAMETERS
//   DBIT     8   data bits per frame (5..8)
//   SB_TICK  16  stop-bit length in s_ticks: 16 = 1, 24 = 1.5, 32 = 2 stop bits
//   PARITY   0   0 = none, 1 = even, 2 = odd
//
// PORTS
//   clk          in   1     system clock; single clock domain
//   rst          in   1     synchronous, active-high reset
//   s_tick       in   1     one-cycle pulse at 16x baud rate
//   fifo_empty   in   1     TX FIFO empty flag
//   fifo_r_data  in   DBIT  TX FIFO head word (valid combinationally while !fifo_empty)
//   fifo_rd      out  1     pop strobe to TX FIFO, one cycle per word
//   tx           out  1     serial line, idle high
//   tx_busy      out  1     high whenever state != IDLE
//   tx_done_tick out  1     one-cycle pulse when last stop tick of a frame completes
//
// BEHAVIOUR
//   Reset (sync, rst=1 at clk edge):
//   - state=IDLE; tx=1; fifo_rd=0; tx_busy=0; tx_done_tick=0; counters 0.
//   - Reset mid-frame aborts: latched word discarded, tx=1 from next cycle, no pop.
//   States: IDLE, START, DATA, PARITY, STOP.
//   - IDLE: tx=1. If !fifo_empty: fifo_rd=1 for this cycle, latch fifo_r_data into shift reg b, s=0, ->START.
//   - START: tx=0. On s_tick: s==15 ? (s=0, n=0, ->DATA) : s++.
//   - DATA: tx=b[0]. On s_tick with s==15: s=0, b>>=1, parity acc ^= b[0]; then n==DBIT-1 ? ->(PARITY!=0 ? PARITY : STOP) : n++. Otherwise s++.
//   - PARITY: tx = even ? ^data : ~^data (data = original latched word). 16 ticks, then ->STOP.
//   - STOP: tx=1. On s_tick with s==SB_TICK-1: tx_done_tick=1, then:
//       - !fifo_empty -> fifo_rd=1, latch, s=0, ->START (back-to-back, no idle gap);
//       - else ->IDLE.
//   Timing rules:
//   - s_tick is ignored in IDLE; the bit period counts only s_tick cycles.
//   - First start bit is 16 ticks measured from the first s_tick after entry.
//   - Tick counter s width = $clog2(max(16, SB_TICK)); bit counter n width = $clog2(DBIT).
//   - fifo_rd is never asserted when fifo_empty=1; at most one pop per frame.
//   - fifo_rd is combinational from state+fifo_empty (same cycle as latch).
//   - tx is registered (no glitches).
//   - Word is captured at pop; later FIFO changes do not affect the frame in flight.
//   - FIFO becoming non-empty mid-frame has no effect until STOP completes.
//
// STRUCTURE
//   - uart_pkg: typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
//     parity encoding localparams PAR_NONE/PAR_EVEN/PAR_ODD (shared with uart_rx).
//   - No sub-module: single FSM with s/n/b/parity registers (next-state + register style).
//   - Baud generator stays a separate sibling.
//
// TESTING (DBIT=8, PARITY=0, SB_TICK=16, s_tick every 4 clks unless noted)
//   1. FIFO holds 0x55 -> one fifo_rd pulse; tx = 0,1,0,1,0,1,0,1,0,1, each held 64 clks; tx_done_tick once; tx_busy falls after.
//   2. FIFO holds 0xA3,0x0F -> two fifo_rd pulses; second start bit begins the cycle after first stop ends (no high gap); 2 done ticks.
//   3. FIFO empty for 1000 clks with s_tick running -> tx=1, fifo_rd=0, tx_busy=0 throughout.
//   4. PARITY=1, word 0x07 -> parity bit 1; PARITY=2, same word -> parity bit 0; frame = 11 bit periods.
//   5. SB_TICK=32, word 0xFF -> stop high for 128 clks before tx_done_tick.
//   6. rst asserted during DATA bit 3 -> next cycle tx=1, tx_busy=0; word is not re-sent; next queued word starts a fresh frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the parity mode
// encoding that both directions of the link agree on.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Tick counter must reach both the 16-tick bit period and the stop length.
  function automatic int tick_cnt_width(input int sb_tick);
    return $clog2((sb_tick > 16) ? sb_tick : 16);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter draining a TX FIFO: start bit, DBIT data bits LSB first,
// optional parity, stop bit(s), each bit timed by 16x oversample ticks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int SW = tick_cnt_width(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_t       state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            par, par_next;
  logic            tx_reg, tx_next;
  logic            rd, done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      par    <= 1'b0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_next;
      s      <= s_next;
      n      <= n_next;
      b      <= b_next;
      par    <= par_next;
      tx_reg <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    par_next   = par;
    rd         = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd         = 1'b1;
          b_next     = fifo_r_data;
          par_next   = 1'b0;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next   = '0;
            b_next   = b >> 1;
            par_next = par ^ b[0];
            if (n == N_LAST) begin
              state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP_LAST) begin
            done   = 1'b1;
            s_next = '0;
            // Back-to-back frames: the next pop happens on the final stop tick.
            if (!fifo_empty) begin
              rd         = 1'b1;
              b_next     = fifo_r_data;
              par_next   = 1'b0;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is computed from the upcoming state so tx lines up with state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:            tx_next = 1'b0;
      DATA:             tx_next = b_next[0];
      uart_pkg::PARITY: tx_next = (PARITY == PAR_EVEN) ? par_next : ~par_next;
      default:          tx_next = 1'b1;
    endcase
  end

  assign fifo_rd      = rd & ~rst;
  assign tx_done_tick = done & ~rst;
  assign tx_busy      = (state != IDLE);
  assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (no parity, even, odd,
// two stop bits) fed from queue-modelled FIFOs and decoded by a line monitor.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] tick_div = 2'd0;
  wire        s_tick = (tick_div == 2'd3);

  logic [3:0] empty_v = 4'hF;
  logic [7:0] rdata [4] = '{default: 8'h00};
  wire  [3:0] rd_v, tx_v, busy_v, done_v;

  logic [7:0] fq0[$], fq1[$], fq2[$], fq3[$];
  logic [7:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int rd_cnt [4] = '{default: 0};
  int done_cnt [4] = '{default: 0};
  int bad_rd = 0;
  bit pend [4] = '{default: 1'b0};

  logic mon_tx, mon_done, mon_busy;

  always #5 clk = ~clk;

  always @(posedge clk) tick_div <= tick_div + 2'd1;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(empty_v[0]), .fifo_r_data(rdata[0]),
    .fifo_rd(rd_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(empty_v[1]), .fifo_r_data(rdata[1]),
    .fifo_rd(rd_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_dut2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(empty_v[2]), .fifo_r_data(rdata[2]),
    .fifo_rd(rd_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_dut3 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .fifo_empty(empty_v[3]), .fifo_r_data(rdata[3]),
    .fifo_rd(rd_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done_tick(done_v[3]));

  always_comb begin
    mon_tx   = tx_v[sel];
    mon_done = done_v[sel];
    mon_busy = busy_v[sel];
  end

  // Pop requests are seen mid-cycle and applied at the edge the DUT latches on.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      pend[i] = rd_v[i];
      if (rd_v[i]) begin
        rd_cnt[i]++;
        if (empty_v[i]) bad_rd++;
      end
      if (done_v[i]) done_cnt[i]++;
    end
  end

  always @(posedge clk) begin
    if (pend[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (pend[1] && fq1.size() != 0) void'(fq1.pop_front());
    if (pend[2] && fq2.size() != 0) void'(fq2.pop_front());
    if (pend[3] && fq3.size() != 0) void'(fq3.pop_front());
    #1;
    empty_v[0] = (fq0.size() == 0); rdata[0] = (fq0.size() != 0) ? fq0[0] : 8'h00;
    empty_v[1] = (fq1.size() == 0); rdata[1] = (fq1.size() != 0) ? fq1[0] : 8'h00;
    empty_v[2] = (fq2.size() == 0); rdata[2] = (fq2.size() != 0) ? fq2[0] : 8'h00;
    empty_v[3] = (fq3.size() == 0); rdata[3] = (fq3.size() != 0) ? fq3[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input int inst, input logic [7:0] w);
    case (inst)
      0: fq0.push_back(w);
      1: fq1.push_back(w);
      2: fq2.push_back(w);
      default: fq3.push_back(w);
    endcase
    exp_q.push_back(w);
  endtask

  // Waits for a start bit on the selected line, then checks every cycle of
  // the frame against the next scoreboard word and decodes it mid-bit.
  task automatic get_frame(input int par_mode, input int sb_ticks, output int gap,
                           output int stop_clks, output int total, output logic par_bit);
    logic [7:0] exp_w, word;
    logic bits [12];
    int nbits, need, clks, tk, bad, len_bad, done_bad;
    bit last;
    gap = 0; stop_clks = 0; total = 0; par_bit = 1'b0; word = 8'h00;
    bad = 0; len_bad = 0; done_bad = 0;
    @(negedge clk);
    while (mon_tx !== 1'b0 && gap < 2000) begin
      gap++;
      @(negedge clk);
    end
    if (gap >= 2000) begin
      check("start_timeout", 32'(gap), 32'd0);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    exp_w = exp_q.pop_front();
    nbits = (par_mode != 0) ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = exp_w[i];
    if (par_mode != 0) bits[9] = (par_mode == 1) ? (^exp_w) : ~(^exp_w);
    bits[nbits-1] = 1'b1;
    for (int bi = 0; bi < nbits; bi++) begin
      if (bi != 0) @(negedge clk);
      need = (bi == nbits - 1) ? sb_ticks : 16;
      clks = 0; tk = 0; last = 1'b0;
      while (!last) begin
        clks++;
        if (mon_tx !== bits[bi] || mon_busy !== 1'b1) bad++;
        if (s_tick) begin
          tk++;
          if (tk == 8) begin
            if (bi >= 1 && bi <= 8) word[bi-1] = mon_tx;
            if (par_mode != 0 && bi == 9) par_bit = mon_tx;
          end
        end
        if (mon_done !== ((tk == need) && (bi == nbits - 1))) done_bad++;
        last = (tk == need) || (clks > 4 * need + 8);
        if (!last) @(negedge clk);
      end
      if (bi != 0 && clks != 4 * need) len_bad++;
      total += clks;
      if (bi == nbits - 1) stop_clks = clks;
    end
    check("frame_bits", 32'(bad), 32'd0);
    check("bit_len", 32'(len_bad), 32'd0);
    check("done_tick", 32'(done_bad), 32'd0);
    check("rx_data", 32'(word), 32'(exp_w));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap, stop_clks, total, r0, d0, bad;
    logic par_bit;
    logic [7:0] w;

    repeat (4) @(negedge clk);
    check("reset_tx", 32'(tx_v), 32'hF);
    check("reset_busy", 32'(busy_v), 32'h0);
    check("reset_rd", 32'(rd_v), 32'h0);
    check("reset_done", 32'(done_v), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single 0x55 frame
    sel = 0; r0 = rd_cnt[0]; d0 = done_cnt[0];
    push_word(0, 8'h55);
    get_frame(0, 16, gap, stop_clks, total, par_bit);
    @(negedge clk);
    check("t1_busy_fall", 32'(mon_busy), 32'd0);
    check("t1_pops", 32'(rd_cnt[0] - r0), 32'd1);
    check("t1_done_cnt", 32'(done_cnt[0] - d0), 32'd1);

    // Two queued words go out back-to-back
    repeat (10) @(negedge clk);
    r0 = rd_cnt[0]; d0 = done_cnt[0];
    push_word(0, 8'hA3);
    push_word(0, 8'h0F);
    get_frame(0, 16, gap, stop_clks, total, par_bit);
    get_frame(0, 16, gap, stop_clks, total, par_bit);
    check("t2_no_gap", 32'(gap), 32'd0);
    @(negedge clk);
    check("t2_busy_fall", 32'(mon_busy), 32'd0);
    check("t2_pops", 32'(rd_cnt[0] - r0), 32'd2);
    check("t2_done_cnt", 32'(done_cnt[0] - d0), 32'd2);

    // Empty FIFO: line stays idle
    bad = 0; r0 = rd_cnt[0];
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0 || rd_v[0] !== 1'b0) bad++;
    end
    check("t3_idle", 32'(bad), 32'd0);
    check("t3_no_pop", 32'(rd_cnt[0] - r0), 32'd0);

    // Even and odd parity on 0x07
    sel = 1;
    push_word(1, 8'h07);
    get_frame(1, 16, gap, stop_clks, total, par_bit);
    check("t4_even_par", 32'(par_bit), 32'd1);
    check("t4_frame_len", 32'(total >= 16 * 4 - 3 + 640 && total <= 16 * 4 + 640), 32'd1);
    sel = 2;
    push_word(2, 8'h07);
    get_frame(2, 16, gap, stop_clks, total, par_bit);
    check("t4_odd_par", 32'(par_bit), 32'd0);
    check("t4_odd_len", 32'(total >= 16 * 4 - 3 + 640 && total <= 16 * 4 + 640), 32'd1);

    // Two stop bits
    sel = 3;
    push_word(3, 8'hFF);
    get_frame(0, 32, gap, stop_clks, total, par_bit);
    check("t5_stop_clks", 32'(stop_clks), 32'd128);
    @(negedge clk);
    check("t5_busy_fall", 32'(mon_busy), 32'd0);

    // Random burst on the plain instance
    sel = 0; r0 = rd_cnt[0];
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom_range(0, 255));
      push_word(0, w);
    end
    for (int i = 0; i < 5; i++) begin
      get_frame(0, 16, gap, stop_clks, total, par_bit);
      if (i != 0) check("rand_no_gap", 32'(gap), 32'd0);
    end
    check("rand_pops", 32'(rd_cnt[0] - r0), 32'd5);

    // Reset in the middle of data bit 3 aborts the frame
    repeat (20) @(negedge clk);
    r0 = rd_cnt[0]; bad = 0;
    push_word(0, 8'h3C);
    push_word(0, 8'h81);
    gap = 0;
    @(negedge clk);
    while (mon_tx !== 1'b0 && gap < 2000) begin
      gap++;
      @(negedge clk);
    end
    check("t6_start_seen", 32'(gap < 2000), 32'd1);
    repeat (276) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_tx", 32'(mon_tx), 32'd1);
    check("t6_rst_busy", 32'(mon_busy), 32'd0);
    rst = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    get_frame(0, 16, gap, stop_clks, total, par_bit);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0) bad++;
    end
    check("t6_idle_after", 32'(bad), 32'd0);
    check("t6_pops", 32'(rd_cnt[0] - r0), 32'd2);

    check("rd_when_empty", 32'(bad_rd), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
